// File: rtl/bus_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bus_xfer_sequencer
// Purpose  : Handshaked AR/DR/PC register-transfer sequencer for the data bus.
// Revision : 1.0  initial release
// ============================================================================
module bus_xfer_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [1:0]       src,
  input  logic [1:0]       dst,
  input  logic             inc_src,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       select,
  output logic             ar_read,
  output logic             dr_read,
  output logic             pc_read,
  output logic             ar_load,
  output logic             dr_load,
  output logic             pc_load,
  output logic             ar_inc,
  output logic             dr_inc,
  output logic             pc_inc,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_LOAD  = 3'd2,
    S_INC   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [1:0] c_sel_idle    = 2'b11;
  localparam logic [1:0] c_settle_init = 2'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_rst_sync;
  logic [1:0]       r_src;
  logic [1:0]       r_dst;
  logic             r_inc;
  logic [1:0]       r_settle;
  logic [CNT_W-1:0] r_count;
  logic             w_invalid;
  logic [2:0]       w_src_oh;
  logic [2:0]       w_dst_oh;
  logic [2:0]       w_rd;
  logic [2:0]       w_ld;
  logic [2:0]       w_in;

  assign w_invalid = (src == 2'b11) || (dst == 2'b11) || (src == dst);
  assign w_src_oh  = 3'b001 << r_src;
  assign w_dst_oh  = 3'b001 << r_dst;

  // Reset asserts asynchronously but the FSM only starts one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 1'b0;
    else        r_rst_sync <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_state <= S_IDLE;
    else if (!r_rst_sync) r_state <= S_IDLE;
    else                  r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src    <= 2'b00;
      r_dst    <= 2'b00;
      r_inc    <= 1'b0;
      r_settle <= 2'b00;
      r_count  <= '0;
    end else if (r_rst_sync) begin
      if (r_state == S_IDLE && req) begin
        r_src    <= src;
        r_dst    <= dst;
        r_inc    <= inc_src;
        r_settle <= c_settle_init;
      end else if (r_state == S_DRIVE && r_settle != 2'b00) begin
        r_settle <= r_settle - 2'b01;
      end
      if (r_state == S_DONE) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    select = c_sel_idle;
    w_rd   = 3'b000;
    w_ld   = 3'b000;
    w_in   = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (req) w_next = w_invalid ? S_ERR : S_DRIVE;
      end
      S_DRIVE: begin
        busy   = 1'b1;
        select = r_src;
        w_rd   = w_src_oh;
        if (r_settle == 2'b00) w_next = S_LOAD;
      end
      S_LOAD: begin
        busy   = 1'b1;
        select = r_src;
        w_rd   = w_src_oh;
        w_ld   = w_dst_oh;
        w_next = r_inc ? S_INC : S_DONE;
      end
      S_INC: begin
        busy   = 1'b1;
        w_in   = w_src_oh;
        w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        err    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign {pc_read, dr_read, ar_read} = w_rd;
  assign {pc_load, dr_load, ar_load} = w_ld;
  assign {pc_inc,  dr_inc,  ar_inc}  = w_in;
  assign xfer_count                  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_xfer_sequencer
// Purpose  : Bench for bus_xfer_sequencer (SETTLE_CYCLES 1 and 3 side by side).
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_xfer_sequencer;

  localparam int N = 4096;
  localparam logic [13:0] IDLE_V = 14'b000_11_000_000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic inc_src = 1'b0;
  logic [1:0] src = 2'b00;
  logic [1:0] dst = 2'b00;

  logic d1_busy, d1_done, d1_err, d1_ar_read, d1_dr_read, d1_pc_read;
  logic d1_ar_load, d1_dr_load, d1_pc_load, d1_ar_inc, d1_dr_inc, d1_pc_inc;
  logic [1:0] d1_select;
  logic [7:0] d1_xfer_count;
  logic d3_busy, d3_done, d3_err, d3_ar_read, d3_dr_read, d3_pc_read;
  logic d3_ar_load, d3_dr_load, d3_pc_load, d3_ar_inc, d3_dr_inc, d3_pc_inc;
  logic [1:0] d3_select;
  logic [7:0] d3_xfer_count;

  always #5 clk = ~clk;

  bus_xfer_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .src(src), .dst(dst), .inc_src(inc_src),
    .busy(d1_busy), .done(d1_done), .err(d1_err), .select(d1_select),
    .ar_read(d1_ar_read), .dr_read(d1_dr_read), .pc_read(d1_pc_read),
    .ar_load(d1_ar_load), .dr_load(d1_dr_load), .pc_load(d1_pc_load),
    .ar_inc(d1_ar_inc), .dr_inc(d1_dr_inc), .pc_inc(d1_pc_inc),
    .xfer_count(d1_xfer_count)
  );

  bus_xfer_sequencer #(.SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .src(src), .dst(dst), .inc_src(inc_src),
    .busy(d3_busy), .done(d3_done), .err(d3_err), .select(d3_select),
    .ar_read(d3_ar_read), .dr_read(d3_dr_read), .pc_read(d3_pc_read),
    .ar_load(d3_ar_load), .dr_load(d3_dr_load), .pc_load(d3_pc_load),
    .ar_inc(d3_ar_inc), .dr_inc(d3_dr_inc), .pc_inc(d3_pc_inc),
    .xfer_count(d3_xfer_count)
  );

  // Output word: {done, err, busy, select, read[PC,DR,AR], load[..], inc[..]}
  function automatic logic [13:0] pk(input logic dn, input logic er, input logic bz,
                                     input logic [1:0] sl, input logic [2:0] rd,
                                     input logic [2:0] ld, input logic [2:0] ic);
    return {dn, er, bz, sl, rd, ld, ic};
  endfunction

  function automatic logic [2:0] oh(input logic [1:0] r);
    logic [2:0] v;
    v = 3'b000;
    if (r != 2'b11) v[r] = 1'b1;
    return v;
  endfunction

  logic [13:0] obs [2];
  logic [7:0]  cnt_obs [2];
  assign obs[0] = pk(d1_done, d1_err, d1_busy, d1_select,
                     {d1_pc_read, d1_dr_read, d1_ar_read},
                     {d1_pc_load, d1_dr_load, d1_ar_load},
                     {d1_pc_inc, d1_dr_inc, d1_ar_inc});
  assign obs[1] = pk(d3_done, d3_err, d3_busy, d3_select,
                     {d3_pc_read, d3_dr_read, d3_ar_read},
                     {d3_pc_load, d3_dr_load, d3_ar_load},
                     {d3_pc_inc, d3_dr_inc, d3_ar_inc});
  assign cnt_obs[0] = d1_xfer_count;
  assign cnt_obs[1] = d3_xfer_count;

  int vecs = 0;
  int miss = 0;

  // Transfer-level model: each accepted request writes its whole expected
  // output timeline into ev[] indexed by the edge that begins the cycle.
  logic [13:0] ev [2][N];
  int cnt [2];
  int since [2];
  int nxt [2];
  int en = -1;
  int ms, mp;

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < N; p++) ev[d][p] = IDLE_V;
      cnt[d] = 0; since[d] = 0; nxt[d] = 0;
    end
    forever begin
      @(posedge clk);
      en++;
      for (int d = 0; d < 2; d++) begin
        ms = (d == 0) ? 1 : 3;
        if (!rst_n) begin
          since[d] = 0; cnt[d] = 0; nxt[d] = 0;
          for (int i = 0; i < 16; i++) ev[d][en+i] = IDLE_V;
        end else begin
          if (since[d] < 2) since[d]++;
          if (en > 0 && ev[d][en-1][13]) cnt[d] = (cnt[d] + 1) % 256;
          if (req && since[d] >= 2 && en >= nxt[d]) begin
            if (src == 2'b11 || dst == 2'b11 || src == dst) begin
              ev[d][en] = pk(1'b0, 1'b1, 1'b0, 2'b11, 3'b0, 3'b0, 3'b0);
              nxt[d] = en + 2;
            end else begin
              for (int i = 0; i < ms; i++)
                ev[d][en+i] = pk(1'b0, 1'b0, 1'b1, src, oh(src), 3'b0, 3'b0);
              ev[d][en+ms] = pk(1'b0, 1'b0, 1'b1, src, oh(src), oh(dst), 3'b0);
              mp = en + ms + 1;
              if (inc_src) begin
                ev[d][mp] = pk(1'b0, 1'b0, 1'b1, 2'b11, 3'b0, 3'b0, oh(src));
                mp++;
              end
              ev[d][mp] = pk(1'b1, 1'b0, 1'b1, 2'b11, 3'b0, 3'b0, 3'b0);
              nxt[d] = mp + 2;
            end
          end
        end
      end
    end
  end

  task automatic model_chk(input int d);
    logic [13:0] e;
    int c;
    e = rst_n ? ev[d][en] : IDLE_V;
    c = rst_n ? cnt[d] : 0;
    vecs++;
    if (obs[d] !== e || cnt_obs[d] !== 8'(c)) begin
      miss++;
      $display("FAIL model[dut%0d] edge %0d: outputs %b count %0d, required %b count %0d",
               (d == 0) ? 1 : 3, en, obs[d], cnt_obs[d], e, c);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (en >= 0) begin
        model_chk(0);
        model_chk(1);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ndone;
  bit found;

  initial begin
    // reset state
    cyc(2);
    lit("rst_select", d1_select, 3);
    lit("rst_busy", d1_busy, 0);
    lit("rst_count", d1_xfer_count, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    cyc(3);

    // AR->DR, no increment
    @(negedge clk); req = 1; src = 2'd0; dst = 2'd1; inc_src = 0;
    @(negedge clk); req = 0;
    lit("ad_c1_select", d1_select, 0);
    lit("ad_c1_ar_read", d1_ar_read, 1);
    lit("ad_c1_dr_load", d1_dr_load, 0);
    @(negedge clk);
    lit("ad_c2_select", d1_select, 0);
    lit("ad_c2_ar_read", d1_ar_read, 1);
    lit("ad_c2_dr_load", d1_dr_load, 1);
    @(negedge clk);
    lit("ad_c3_done", d1_done, 1);
    @(negedge clk);
    lit("ad_c4_done", d1_done, 0);
    lit("ad_c4_count", d1_xfer_count, 1);
    cyc(4);

    // PC->AR with increment, SETTLE_CYCLES=3
    @(negedge clk); req = 1; src = 2'd2; dst = 2'd0; inc_src = 1;
    @(negedge clk); req = 0;
    lit("pa_c1_select", d3_select, 2);
    cyc(3);
    lit("pa_c4_select", d3_select, 2);
    lit("pa_c4_ar_load", d3_ar_load, 1);
    cyc(1);
    lit("pa_c5_pc_inc", d3_pc_inc, 1);
    lit("pa_c5_select", d3_select, 3);
    lit("pa_c5_pc_read", d3_pc_read, 0);
    cyc(1);
    lit("pa_c6_done", d3_done, 1);
    cyc(3);

    // invalid requests
    @(negedge clk); req = 1; src = 2'd1; dst = 2'd1; inc_src = 0;
    @(negedge clk); req = 0;
    lit("inv1_err", d1_err, 1);
    lit("inv1_busy", d1_busy, 0);
    lit("inv1_strobes", int'(obs[0][8:0]), 0);
    lit("inv1_count", d1_xfer_count, 2);
    cyc(2);
    @(negedge clk); req = 1; src = 2'd3; dst = 2'd0;
    @(negedge clk); req = 0;
    lit("inv2_err", d1_err, 1);
    lit("inv2_busy", d1_busy, 0);
    lit("inv2_strobes", int'(obs[0][8:0]), 0);
    lit("inv2_count", d1_xfer_count, 2);
    cyc(2);

    // request held high through DR->PC transfers
    @(negedge clk); req = 1; src = 2'd1; dst = 2'd2; inc_src = 0;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 8) req = 0;
      ndone += int'(d1_done);
      if (c == 2) lit("hold_c2_pc_load", d1_pc_load, 1);
      if (c == 4) lit("hold_c4_busy", d1_busy, 0);
      if (c == 5) lit("hold_c5_select", d1_select, 1);
    end
    lit("hold_done_pulses", ndone, 2);
    cyc(12);

    // reset mid-DRIVE of AR->DR
    @(negedge clk); req = 1; src = 2'd0; dst = 2'd1; inc_src = 0;
    @(negedge clk); req = 0;
    #2 rst_n = 1'b0;
    #1;
    lit("mid_rst_select", d1_select, 3);
    lit("mid_rst_strobes", int'(obs[0][8:0]), 0);
    lit("mid_rst_busy", d1_busy, 0);
    lit("mid_rst_count", d1_xfer_count, 0);
    model_chk(0);
    model_chk(1);
    @(negedge clk); #2 rst_n = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      ndone += int'(d1_done) + int'(d3_done);
    end
    lit("mid_rst_no_done", ndone, 0);

    // counter wrap
    @(negedge clk); req = 1; src = 2'd0; dst = 2'd1; inc_src = 0;
    found = 0;
    for (int i = 0; i < 1500 && !found; i++) begin
      @(negedge clk);
      if (d1_xfer_count == 8'd255) found = 1;
    end
    lit("wrap_reach_255", found ? 255 : int'(d1_xfer_count), 255);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (d1_xfer_count != 8'd255) found = 1;
    end
    lit("wrap_to_0", found ? int'(d1_xfer_count) : 255, 0);
    req = 0;
    cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_xfer_sequencer.md
# bus_xfer_sequencer

Control sequencer placed directly upstream of the shared data bus and the AR/DR/PC register group. On a single transfer request it drives the bus `select`, the source register's `read`, the destination register's `load`, and, when requested, a post-increment of the source. It replaces hand-timed control sequences with a handshaked, cycle-exact register-transfer engine, and keeps a count of completed transfers.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the source drives the bus before the destination load; legal range 1–4.
- `CNT_W`, default 8: width of `xfer_count`.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, 1: start a transfer; sampled only in IDLE.
- `src`, in, 2: source register; 00=AR, 01=DR, 10=PC, 11=invalid.
- `dst`, in, 2: destination register; same encoding as `src`.
- `inc_src`, in, 1: increment the source after the load.
- `busy`, out, 1: high from the cycle after an accepted `req` through the DONE cycle.
- `done`, out, 1: one-cycle pulse when a transfer completes.
- `err`, out, 1: one-cycle pulse when a request is rejected.
- `select`, out, 2: bus source select; 11 when idle.
- `ar_read`, `dr_read`, `pc_read`, out, 1 each: source output enables.
- `ar_load`, `dr_load`, `pc_load`, out, 1 each: destination load strobes.
- `ar_inc`, `dr_inc`, `pc_inc`, out, 1 each: increment strobes.
- `xfer_count`, out, `CNT_W`: number of completed transfers, modulo 2^`CNT_W`.

## Operation
- The FSM has states IDLE, DRIVE, LOAD, INC, DONE and ERR. All outputs decode from registered state and latched fields, so there is no combinational path from input to output.
- **IDLE:** outputs are 0, except `select`=11. At a rising edge with `req`=1, the block latches `src`, `dst` and `inc_src`.
  - If the request is invalid, go to ERR. Invalid means `src`=11, `dst`=11, or `src`==`dst`.
  - Otherwise go to DRIVE and load the settle counter with `SETTLE_CYCLES`-1.
- **DRIVE:** `select`=src, the source `*_read`=1, `busy`=1. The block stays here until the settle counter reaches 0, decrementing each cycle, then goes to LOAD.
- **LOAD:** same as DRIVE, plus the destination `*_load`=1 for exactly one cycle. Next state is INC if the latched `inc_src`=1, else DONE.
- **INC:** the source `*_inc`=1 for one cycle. `select` returns to 11 and all reads and loads are 0. Next state is DONE.
- **DONE:** `done`=1 and `busy`=1. `xfer_count` increments on the edge leaving DONE; it wraps all-ones to 0. Next state is IDLE.
- **ERR:** `err`=1 and `busy`=0. There is no bus activity and `xfer_count` does not change. Next state is IDLE.
- `req` is ignored in every state except IDLE. A request held high re-triggers only on the first edge back in IDLE.
- At most one `*_read`, one `*_load` and one `*_inc` is high in any cycle. Read and inc never target the same register in the same cycle.
- **Reset (`rst_n` low, including mid-transfer):** every output goes to 0 immediately, with `select`=11 and `xfer_count`=0. State returns to IDLE and the partial transfer is abandoned without a `done`.

## Timing
- Request accepted at edge k. DRIVE occupies cycles k+1 … k+`SETTLE_CYCLES`, and LOAD is cycle k+`SETTLE_CYCLES`+1.
- The destination register captures the bus on the edge that ends LOAD, while its `*_load` is high.
- `done` latency after the `req` edge is `SETTLE_CYCLES`+2 cycles without increment, or `SETTLE_CYCLES`+3 with `inc_src`. With the default parameters this is 3 or 4 cycles.
- An invalid request produces `err` in cycle k+1. The earliest next acceptance is edge k+2.
- Back-to-back transfers: the next `req` can be accepted on the edge that leaves DONE into IDLE, plus one cycle, giving a minimum period of latency+1.
- Reset is asserted asynchronously and released synchronously; the first `req` is sampled on the second edge after `rst_n` rises.

## Test plan
- **Reset:** drive `rst_n`=0 mid-DRIVE of an AR→DR transfer. Required: `select`=11, all strobes 0, `busy`=0 and `xfer_count`=0 immediately, and no `done` afterwards.
- **AR→DR, no increment, default parameters:** `req` at edge 0. Required:
  - `select`=00 with `ar_read`=1 in cycles 1–2.
  - `dr_load`=1 only in cycle 2.
  - `done` in cycle 3.
  - `xfer_count`=1 afterwards.
- **PC→AR with `inc_src`=1 and `SETTLE_CYCLES`=3:** Required:
  - `select`=10 in cycles 1–4.
  - `ar_load` in cycle 4.
  - `pc_inc` in cycle 5, with `select`=11 in that cycle.
  - `done` in cycle 6.
- **Invalid requests:** `src`=`dst`=01, then `src`=11. Required for each: an `err` pulse one cycle later, no read, load or inc strobes, `busy`=0, and `xfer_count` unchanged.
- **Request during busy:** hold `req` high through a DR→PC transfer. Required: exactly one `done` per transfer, the second transfer starting one cycle after DONE, and `req` ignored during DRIVE, LOAD and INC.
- **Counter wrap:** with `CNT_W`=8, run 256 valid transfers. Required: `xfer_count` reads 255 and then returns to 0.
